// File: rtl/fwd_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding/hazard controller:
//   - source-select codes driven to reg_bank on mux_sel_A / mux_sel_B
//   - default register address width and track-entry field widths
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int REG_AW_DEF = 5;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_RF = 2'b00;  // register file
    localparam sel_t SEL_EX = 2'b01;  // ans_ex
    localparam sel_t SEL_DM = 2'b10;  // ans_dm
    localparam sel_t SEL_WB = 2'b11;  // ans_wb

    // Track entry layout: {valid, rd[REG_AW], we, ld}
    localparam int VALID_W = 1;
    localparam int WE_W    = 1;
    localparam int LD_W    = 1;
    localparam int ENTRY_W = VALID_W + REG_AW_DEF + WE_W + LD_W;

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_ctrl_unit_if
// Decode-stage handshake between the decoder, the forwarding controller and
// reg_bank.
//   Decode side : RA, RB, use_ra, use_rb, RW_id, we_id, ld_id, flush
//   Select side : mux_sel_A, mux_sel_B, imm_sel, RW_dm, we_dm, stall
// modport master : the forwarding controller (consumes decode, drives selects)
// modport slave  : the decoder / reg_bank side (drives decode, consumes selects)
// -----------------------------------------------------------------------------
interface fwd_ctrl_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] RA;
    logic [REG_AW-1:0] RB;
    logic              use_ra;
    logic              use_rb;
    logic [REG_AW-1:0] RW_id;
    logic              we_id;
    logic              ld_id;
    logic              flush;

    sel_t              mux_sel_A;
    sel_t              mux_sel_B;
    logic              imm_sel;
    logic [REG_AW-1:0] RW_dm;
    logic              we_dm;
    logic              stall;

    modport master (
        input  RA, RB, use_ra, use_rb, RW_id, we_id, ld_id, flush,
        output mux_sel_A, mux_sel_B, imm_sel, RW_dm, we_dm, stall
    );

    modport slave (
        output RA, RB, use_ra, use_rb, RW_id, we_id, ld_id, flush,
        input  mux_sel_A, mux_sel_B, imm_sel, RW_dm, we_dm, stall
    );

endinterface

// File: rtl/fwd_track_stage.sv
// -----------------------------------------------------------------------------
// fwd_track_stage
// One pipeline track entry {valid, rd, we, ld}. Loads its input every clock;
// a bubble clears valid and we so the slot can never match or write back.
//   clk, rst          : clock, synchronous active-high reset (clears entry)
//   bubble            : insert an empty slot instead of the incoming entry
//   valid_in .. ld_in : incoming entry
//   valid_q  .. ld_q  : registered entry
// -----------------------------------------------------------------------------
module fwd_track_stage #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              valid_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              we_in,
    input  logic              ld_in,
    output logic              valid_q,
    output logic [REG_AW-1:0] rd_q,
    output logic              we_q,
    output logic              ld_q
);

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            valid_q <= valid_in & ~bubble;
            rd_q    <= rd_in;
            we_q    <= we_in & ~bubble;
            ld_q    <= ld_in;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// -----------------------------------------------------------------------------
// fwd_ctrl_unit
// Forwarding and load-use hazard controller for the decode stage. Tracks the
// destination of in-flight instructions in EX, DM and WB, and selects the
// youngest producer of each decode source operand for reg_bank.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (drops all in-flight entries)
//   bus : fwd_ctrl_unit_if.master
//         in : RA, RB, use_ra, use_rb, RW_id, we_id, ld_id, flush
//         out: mux_sel_A, mux_sel_B (00 RF, 01 EX, 10 DM, 11 WB), imm_sel,
//              RW_dm, we_dm (write-back port), stall (load-use hold)
// -----------------------------------------------------------------------------
module fwd_ctrl_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    fwd_ctrl_unit_if.master bus
);

    logic              ex_valid, dm_valid, wb_valid;
    logic [REG_AW-1:0] ex_rd,    dm_rd,    wb_rd;
    logic              ex_we,    dm_we,    wb_we;
    logic              ex_ld,    dm_ld,    wb_ld;

    // Only the EX entry's load flag drives the hazard; DM/WB copies just ride along.
    logic unused_ld;
    assign unused_ld = dm_ld ^ wb_ld;

    // Writes to R0 are dropped at capture so R0 can never be forwarded.
    logic id_we;
    assign id_we = bus.we_id & (bus.RW_id != '0);

    fwd_track_stage #(.REG_AW(REG_AW)) u_ex (
        .clk      (clk),
        .rst      (rst),
        .bubble   (bus.stall | bus.flush),
        .valid_in (1'b1),
        .rd_in    (bus.RW_id),
        .we_in    (id_we),
        .ld_in    (bus.ld_id),
        .valid_q  (ex_valid),
        .rd_q     (ex_rd),
        .we_q     (ex_we),
        .ld_q     (ex_ld)
    );

    fwd_track_stage #(.REG_AW(REG_AW)) u_dm (
        .clk      (clk),
        .rst      (rst),
        .bubble   (1'b0),
        .valid_in (ex_valid),
        .rd_in    (ex_rd),
        .we_in    (ex_we),
        .ld_in    (ex_ld),
        .valid_q  (dm_valid),
        .rd_q     (dm_rd),
        .we_q     (dm_we),
        .ld_q     (dm_ld)
    );

    fwd_track_stage #(.REG_AW(REG_AW)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .bubble   (1'b0),
        .valid_in (dm_valid),
        .rd_in    (dm_rd),
        .we_in    (dm_we),
        .ld_in    (dm_ld),
        .valid_q  (wb_valid),
        .rd_q     (wb_rd),
        .we_q     (wb_we),
        .ld_q     (wb_ld)
    );

    function automatic logic stage_hit(
        input logic              valid,
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r
    );
        return valid & we & (rd == r) & (r != '0);
    endfunction

    // Youngest producer wins: EX holds the newest result, WB the oldest.
    function automatic sel_t pick_src(
        input logic              use_r,
        input logic [REG_AW-1:0] r
    );
        sel_t sel;
        sel = SEL_RF;
        if (use_r) begin
            if (stage_hit(ex_valid, ex_we, ex_rd, r))      sel = SEL_EX;
            else if (stage_hit(dm_valid, dm_we, dm_rd, r)) sel = SEL_DM;
            else if (stage_hit(wb_valid, wb_we, wb_rd, r)) sel = SEL_WB;
        end
        return sel;
    endfunction

    // NOTE: every output of this block is assigned a default before any branch,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        bus.mux_sel_A = SEL_RF;
        bus.mux_sel_B = SEL_RF;
        bus.stall     = 1'b0;

        bus.mux_sel_A = pick_src(bus.use_ra, bus.RA);
        bus.mux_sel_B = pick_src(bus.use_rb, bus.RB);

        // A load in EX has no data until DM, so a dependent decode waits one cycle.
        if (ex_ld) begin
            bus.stall = (bus.use_ra & stage_hit(ex_valid, ex_we, ex_rd, bus.RA)) |
                        (bus.use_rb & stage_hit(ex_valid, ex_we, ex_rd, bus.RB));
        end
    end

    assign bus.imm_sel = ~bus.use_rb;
    assign bus.RW_dm   = dm_rd;
    assign bus.we_dm   = dm_valid & dm_we;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
module tb_fwd_ctrl_unit;
    import fwd_pkg::*;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_ctrl_unit_if #(.REG_AW(AW)) bus ();

    fwd_ctrl_unit #(.REG_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          rst;
        logic [AW-1:0] ra, rb;
        logic          ura, urb;
        logic [AW-1:0] rw;
        logic          we, ld, fl;
        logic          chk, chk_sel;
        logic [1:0]    a, b;
        logic          st, wedm;
        logic [AW-1:0] rwdm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input int ra, input int rb, input logic ura, input logic urb,
                       input int rw, input logic we, input logic ld, input logic fl,
                       input logic chk, input logic cs, input int a, input int b,
                       input logic st, input logic wedm, input int rwdm);
        vec_t v;
        v.rst = r; v.ra = AW'(ra); v.rb = AW'(rb); v.ura = ura; v.urb = urb;
        v.rw = AW'(rw); v.we = we; v.ld = ld; v.fl = fl; v.chk = chk; v.chk_sel = cs;
        v.a = 2'(a); v.b = 2'(b); v.st = st; v.wedm = wedm; v.rwdm = AW'(rwdm);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic ura, input logic urb, input logic [AW-1:0] rw,
                         input logic we, input logic ld, input logic fl);
        rst = r; bus.RA = ra; bus.RB = rb; bus.use_ra = ura; bus.use_rb = urb;
        bus.RW_id = rw; bus.we_id = we; bus.ld_id = ld; bus.flush = fl;
    endtask

    // ---------------- reference model ----------------
    // Window of the three most recent decode captures: hist[0]=EX, [1]=DM, [2]=WB.
    typedef struct { logic valid; logic [AW-1:0] rd; logic we; logic ld; } ent_t;
    ent_t hist[3];

    function automatic logic writes(input ent_t e, input logic [AW-1:0] r);
        return e.valid && e.we && e.rd == r && r != 0;
    endfunction

    function automatic logic [1:0] m_sel(input logic use_r, input logic [AW-1:0] r);
        if (!use_r) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (writes(hist[i], r)) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        return hist[0].ld && ((bus.use_ra && writes(hist[0], bus.RA)) ||
                              (bus.use_rb && writes(hist[0], bus.RB)));
    endfunction

    task automatic model_edge();
        ent_t cap;
        logic st;
        st = m_stall();
        cap.valid = !st && !bus.flush;
        cap.rd    = bus.RW_id;
        cap.we    = cap.valid && bus.we_id && bus.RW_id != 0;
        cap.ld    = bus.ld_id;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '{1'b0, '0, 1'b0, 1'b0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cap;
        end
    endtask

    initial begin
        // Directed sequence: inputs for the cycle, expected outputs in that cycle.
        //   rst ra rb ua ub rw we ld fl | chk cs  a  b st wedm rwdm
        add(1, 5, 6, 1, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
        add(1, 5, 6, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // reset state
        add(0, 5, 6, 1, 1, 7, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // ADD r7
        add(0, 7, 6, 1, 1, 0, 0, 0, 0,  1, 1,  1, 0, 0, 0, 0);   // from EX
        add(0, 7, 6, 1, 1, 0, 0, 0, 0,  1, 1,  2, 0, 0, 1, 7);   // from DM
        add(0, 7, 6, 1, 1, 0, 0, 0, 0,  1, 1,  3, 0, 0, 0, 0);   // from WB
        add(0, 7, 6, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // retired
        add(0, 0, 0, 1, 1, 7, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // writer r7
        add(0, 7, 7, 1, 1, 7, 1, 0, 0,  1, 1,  1, 1, 0, 0, 0);   // writer r7 again
        add(0, 7, 7, 1, 1, 0, 0, 0, 0,  1, 1,  1, 1, 0, 1, 7);   // EX beats DM
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 1, 7);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 9, 1, 1, 0,  1, 1,  0, 0, 0, 0, 0);   // LW r9
        add(0, 9, 0, 1, 1, 0, 0, 0, 0,  1, 0,  0, 0, 1, 0, 0);   // load-use stall
        add(0, 9, 0, 1, 1, 0, 0, 0, 0,  1, 1,  2, 0, 0, 1, 9);   // resolved from DM
        add(0, 0, 0, 1, 1, 0, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // writer r0
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // r0 never forwarded
        add(0, 0, 0, 1, 1,11, 1, 1, 0,  1, 1,  0, 0, 0, 0, 0);   // LW r11
        add(0, 3,11, 1, 0, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // imm B, no stall
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 1,11);
        add(0, 0, 0, 1, 1, 7, 1, 0, 1,  1, 1,  0, 0, 0, 0, 0);   // flushed ADD r7
        add(0, 7, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // nothing to forward
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 7);   // bubble in DM
        add(0, 0, 0, 1, 1, 7, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 8, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,10, 1, 0, 0,  1, 1,  0, 0, 0, 1, 7);
        add(1, 7, 8, 1, 1, 0, 0, 0, 0,  1, 1,  3, 2, 0, 1, 8);   // reset mid-flight
        add(0, 7,10, 1, 1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0);   // all dropped
        add(0, 0, 0, 1, 1,12, 1, 1, 0,  1, 1,  0, 0, 0, 0, 0);   // LW r12
        add(0,12, 0, 1, 1, 0, 0, 0, 1,  1, 0,  0, 0, 1, 0, 0);   // flush + stall
        add(0,12, 0, 1, 1, 0, 0, 0, 0,  1, 1,  2, 0, 0, 1,12);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].ura, vecs[i].urb,
                  vecs[i].rw, vecs[i].we, vecs[i].ld, vecs[i].fl);
            #1;
            if (vecs[i].chk) begin
                if (vecs[i].chk_sel) begin
                    check($sformatf("v%0d mux_sel_A", i), 8'(bus.mux_sel_A), 8'(vecs[i].a));
                    check($sformatf("v%0d mux_sel_B", i), 8'(bus.mux_sel_B), 8'(vecs[i].b));
                end
                check($sformatf("v%0d stall", i),   8'(bus.stall),   8'(vecs[i].st));
                check($sformatf("v%0d we_dm", i),   8'(bus.we_dm),   8'(vecs[i].wedm));
                check($sformatf("v%0d RW_dm", i),   8'(bus.RW_dm),   8'(vecs[i].rwdm));
                check($sformatf("v%0d imm_sel", i), 8'(bus.imm_sel), 8'(!vecs[i].urb));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // ---------------- randomized phase against the model ----------------
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        model_edge();
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 39) == 0),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            #1;
            check("rnd stall",   8'(bus.stall),   8'(m_stall()));
            check("rnd we_dm",   8'(bus.we_dm),   8'(hist[1].valid && hist[1].we));
            check("rnd RW_dm",   8'(bus.RW_dm),   8'(hist[1].rd));
            check("rnd imm_sel", 8'(bus.imm_sel), 8'(!bus.use_rb));
            if (!m_stall()) begin
                check("rnd mux_sel_A", 8'(bus.mux_sel_A), 8'(m_sel(bus.use_ra, bus.RA)));
                check("rnd mux_sel_B", 8'(bus.mux_sel_B), 8'(m_sel(bus.use_rb, bus.RB)));
            end
            model_edge();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
